// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - state codes, default sizing and helpers shared by the dCPU sequencer
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_FETCH  = 3'd0,
    SEQ_DECODE = 3'd1,
    SEQ_EXEC   = 3'd2,
    SEQ_MEM    = 3'd3,
    SEQ_WB     = 3'd4,
    SEQ_HALT   = 3'd5
  } seq_state_e;

  localparam int SEQ_XLEN    = 32;
  localparam int SEQ_TIMEOUT = 16;
  localparam int SEQ_TO_W    = 5;

  function automatic logic needs_mem(input logic is_load, input logic is_store);
    return is_load | is_store;
  endfunction

endpackage

// File: rtl/cpu_sequencer_watchdog.sv
// rtl/cpu_sequencer_watchdog.sv - seq_watchdog: bus wait counter, expires on the TIMEOUT-th unanswered cycle
module seq_watchdog
  import cpu_sequencer_pkg::*;
#(
  parameter int TIMEOUT = SEQ_TIMEOUT,
  parameter int TO_W    = SEQ_TO_W
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ready,
  output logic expire
);

  logic [TO_W-1:0] count;

  // Requests never span two states back to back without a handshake, so
  // clearing on !req or ready also covers every state change.
  always_ff @(posedge clk) begin
    if (rst || !req || ready) begin
      count <= '0;
    end else begin
      count <= count + TO_W'(1);
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_on
      localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);
      assign expire = req && !ready && (count == LAST);
    end else begin : g_off
      assign expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control FSM with bus watchdog
// DCPU_PERF_CNT_EN adds cycle_cnt and instret performance counters.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int XLEN    = SEQ_XLEN,
  parameter int TIMEOUT = SEQ_TIMEOUT,
  parameter int TO_W    = SEQ_TO_W
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] ir,
  input  logic            dec_is_load,
  input  logic            dec_is_store,
  input  logic            dec_reg_we,
  input  logic            dec_is_halt,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  output logic            rf_we,
  output logic            pc_we,
  output logic            halted,
  output logic            bus_err,
  output logic [2:0]      state
`ifdef DCPU_PERF_CNT_EN
  ,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     instret
`endif
);

  seq_state_e      state_q, state_d;
  logic [XLEN-1:0] ir_q;
  logic            bus_err_q;
  logic            wd_req, wd_ready, expire;

  // Derived from the state register, not from the FSM outputs, to keep the
  // watchdog out of a combinational loop with the next-state logic.
  assign wd_req   = !rst && (state_q == SEQ_FETCH || state_q == SEQ_MEM);
  assign wd_ready = (state_q == SEQ_FETCH && imem_ready) ||
                    (state_q == SEQ_MEM && dmem_ready);

  seq_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .req    (wd_req),
    .ready  (wd_ready),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEQ_FETCH;
      ir_q      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == SEQ_FETCH && imem_ready) begin
        ir_q <= imem_rdata;
      end
      if (expire) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  // All requests and strobes are held low while rst is asserted.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    halted   = 1'b0;
    if (!rst) begin
      case (state_q)
        SEQ_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            state_d = SEQ_DECODE;
          end else if (expire) begin
            state_d = SEQ_HALT;
          end
        end
        SEQ_DECODE: begin
          state_d = dec_is_halt ? SEQ_HALT : SEQ_EXEC;
        end
        SEQ_EXEC: begin
          state_d = needs_mem(dec_is_load, dec_is_store) ? SEQ_MEM : SEQ_WB;
        end
        SEQ_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = dec_is_store;
          if (dmem_ready) begin
            if (dec_is_store) begin
              pc_we   = 1'b1;
              state_d = SEQ_FETCH;
            end else begin
              state_d = SEQ_WB;
            end
          end else if (expire) begin
            state_d = SEQ_HALT;
          end
        end
        SEQ_WB: begin
          rf_we   = dec_reg_we | dec_is_load;
          pc_we   = 1'b1;
          state_d = SEQ_FETCH;
        end
        SEQ_HALT: begin
          halted = 1'b1;
        end
        default: begin
          state_d = SEQ_HALT;
        end
      endcase
    end
  end

  assign ir      = ir_q;
  assign bus_err = bus_err_q;
  assign state   = state_q;

`ifdef DCPU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      if (state_q != SEQ_HALT) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if (pc_we) begin
        instret <= instret + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer with a retire scoreboard
module tb_cpu_sequencer;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_HALT  = 3;

  typedef struct {
    logic        rf;
    logic [31:0] ir;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ready;
  logic [31:0] imem_rdata, ir;
  logic        dec_is_load, dec_is_store, dec_reg_we, dec_is_halt;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        rf_we, pc_we, halted, bus_err;
  logic [2:0]  state;
`ifdef DCPU_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  cpu_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .ir           (ir),
    .dec_is_load  (dec_is_load),
    .dec_is_store (dec_is_store),
    .dec_reg_we   (dec_reg_we),
    .dec_is_halt  (dec_is_halt),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ready   (dmem_ready),
    .rf_we        (rf_we),
    .pc_we        (pc_we),
    .halted       (halted),
    .bus_err      (bus_err),
    .state        (state)
`ifdef DCPU_PERF_CNT_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret      (instret)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    chk({name, ":sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({name, ":retire_rf_we"}, 64'(rf_we), 64'(e.rf));
      chk({name, ":retire_ir"}, 64'(ir), 64'(e.ir));
    end
  endtask

  // One instruction, cycle by cycle; starts in a FETCH cycle, ends at the next one.
  task automatic do_instr(input string name, input logic [31:0] insn, input int kind,
                          input logic reg_we, input int iwait, input int dwait);
    exp_t e;
    logic mem, st;
    mem          = (kind == K_LOAD) || (kind == K_STORE);
    st           = (kind == K_STORE);
    dec_is_load  = (kind == K_LOAD);
    dec_is_store = st;
    dec_is_halt  = (kind == K_HALT);
    dec_reg_we   = reg_we;
    if (kind != K_HALT) begin
      e.rf = reg_we | (kind == K_LOAD);
      e.ir = insn;
      sb.push_back(e);
    end
    imem_rdata = insn;
    for (int i = 0; i <= iwait; i++) begin
      imem_ready = (i == iwait);
      #2;
      chk({name, ":fetch_state"}, 64'(state), 64'd0);
      chk({name, ":fetch_req"}, 64'({imem_req, dmem_req, bus_err}), 64'b100);
      tick();
    end
    imem_ready = 1'b0;
    imem_rdata = 32'hdead_beef;
    #2;
    chk({name, ":decode_state"}, 64'(state), 64'd1);
    chk({name, ":decode_ir"}, 64'(ir), 64'(insn));
    chk({name, ":decode_req_drop"}, 64'(imem_req), 64'd0);
    tick();
    if (kind == K_HALT) begin
      #2;
      chk({name, ":halt_state"}, 64'({state, halted}), 64'({3'd5, 1'b1}));
      tick();
    end else begin
      #2;
      chk({name, ":exec_state"}, 64'({state, pc_we, rf_we}), 64'({3'd2, 2'b00}));
      tick();
      if (mem) begin
        for (int j = 0; j <= dwait; j++) begin
          dmem_ready = (j == dwait);
          #2;
          chk({name, ":mem_state"}, 64'(state), 64'd3);
          chk({name, ":mem_req_we"}, 64'({dmem_req, dmem_we, imem_req, rf_we}),
              64'({1'b1, st, 1'b0, 1'b0}));
          chk({name, ":mem_pc_we"}, 64'(pc_we), 64'(st && (j == dwait)));
          if (st && (j == dwait)) pop_check(name);
          tick();
        end
        dmem_ready = 1'b0;
      end
      if (!st) begin
        #2;
        chk({name, ":wb_state"}, 64'({state, pc_we, dmem_req}), 64'({3'd4, 1'b1, 1'b0}));
        pop_check(name);
        tick();
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    imem_ready   = 1'b0;
    imem_rdata   = 32'h0;
    dec_is_load  = 1'b0;
    dec_is_store = 1'b0;
    dec_reg_we   = 1'b0;
    dec_is_halt  = 1'b0;
    dmem_ready   = 1'b0;

    tick();
    tick();
    #2;
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_ir", 64'(ir), 64'd0);
    chk("reset_outs", 64'({imem_req, dmem_req, dmem_we, rf_we, pc_we, halted, bus_err}), 64'd0);
    rst = 1'b0;

    do_instr("addi", 32'h0050_0093, K_ALU, 1'b1, 0, 0);
    do_instr("lw", 32'h0000_a103, K_LOAD, 1'b1, 0, 3);
    do_instr("sw", 32'h0020_a023, K_STORE, 1'b0, 0, 1);
    do_instr("nowb", 32'h0020_8463, K_ALU, 1'b0, 2, 0);
    do_instr("fetch16", 32'h0010_0113, K_ALU, 1'b1, 15, 0);
    #2;
    chk("fetch16_no_err", 64'({bus_err, halted}), 64'd0);
`ifdef DCPU_PERF_CNT_EN
    chk("instret_5", 64'(instret), 64'd5);
`endif

    // reset during a stalled load
    dec_is_load  = 1'b1;
    dec_is_store = 1'b0;
    dec_is_halt  = 1'b0;
    dec_reg_we   = 1'b1;
    imem_rdata   = 32'h0041_2183;
    imem_ready   = 1'b1;
    tick();
    imem_ready = 1'b0;
    tick();
    tick();
    #2;
    chk("rstmem_req_before", 64'({state, dmem_req}), 64'({3'd3, 1'b1}));
    tick();
    #2;
    rst = 1'b1;
    tick();
    #2;
    chk("rstmem_after", 64'({state, dmem_req, pc_we, rf_we}), 64'({3'd0, 3'b000}));
`ifdef DCPU_PERF_CNT_EN
    chk("rstmem_instret", 64'(instret), 64'd0);
`endif
    rst = 1'b0;

    // imem never answers: watchdog fires on the 16th waiting cycle
    for (int i = 0; i < 16; i++) begin
      imem_ready = 1'b0;
      #2;
      chk("to_waiting", 64'({state, imem_req, bus_err}), 64'({3'd0, 1'b1, 1'b0}));
      tick();
    end
    #2;
    chk("to_fired", 64'({state, bus_err, halted, imem_req}), 64'({3'd5, 3'b110}));
    rst = 1'b1;
    tick();
    #2;
    chk("to_rst_clear", 64'({state, bus_err, halted}), 64'd0);
    rst = 1'b0;
    dec_is_load = 1'b0;

    do_instr("halt", 32'h0010_0073, K_HALT, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      #2;
      chk("halt_quiet", 64'({halted, imem_req, dmem_req, pc_we, rf_we}), 64'b10000);
      tick();
    end
    rst = 1'b1;
    dec_is_halt = 1'b0;
    tick();
    #2;
    chk("halt_rst", 64'({state, halted}), 64'd0);
    rst = 1'b0;

    do_instr("addi2", 32'h0030_0193, K_ALU, 1'b1, 1, 0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
